deadlock_monitor_scheduler: RTL and testbench
=============================================

// Module: deadlock_monitor_scheduler
// PURPOSE
//  Scans the block/idle outputs of the per-instance AXIS deadlock monitors in the
//  FC_CIF co-sim harness. Confirms that a block persists, and arbitrates round-robin
//  when several instances are flagged at once. Reports one confirmed deadlock at a time
//  over a valid/ready channel, with instance index and cycle stamp. Sits above the
//  per-instance monitors and drives the top-level deadlock flag.
// PARAMETERS
//  NUM_MON        8   number of monitored instances (>=2, need not be a power of 2)
//  IDX_W          3   width of instance index, ceil(log2(NUM_MON))
//  CONFIRM_CYCLES 16  consecutive qualified cycles needed to confirm a block (>=1)
//  CNT_W          5   confirm-counter width, must hold CONFIRM_CYCLES-1
//  STAMP_W        32  width of free-running cycle stamp
// PORTS
//  clock         in   1         clock, rising edge
//  reset         in   1         reset, synchronous, active-high
//  enable        in   1         scheduler run enable
//  mon_block     in   NUM_MON   per-instance block flag from the monitors
//  mon_idle      in   NUM_MON   per-instance idle flag; a set bit disqualifies that block
//  report_valid  out  1         confirmed deadlock report available
//  report_ready  in   1         report consumer ready
//  report_idx    out  IDX_W     index of the deadlocked instance
//  report_stamp  out  STAMP_W   stamp value in the cycle the block was confirmed
//  deadlock      out  1         sticky flag, set on report handshake
//  clear         in   1         clears deadlock and resumes scanning
// BEHAVIOUR
//  Reset: state=IDLE; ptr, cand, cnt, stamp=0; report_valid, report_idx, report_stamp,
//   deadlock=0. Reset asserted in any state, including mid-CONFIRM or REPORT,
//   overrides everything in that cycle.
//  stamp: +1 every non-reset cycle and wraps at 2^STAMP_W. The first cycle after reset
//   has stamp=0.
//  qual[i] = mon_block[i] & ~mon_idle[i].
//  States:
//  - IDLE: if enable=1, go to SCAN next cycle; otherwise stay in IDLE.
//  - SCAN:
//    - If enable=0, go to IDLE.
//    - Otherwise find the first i with qual[i]=1, searching ptr, ptr+1, ... mod NUM_MON.
//      The search wraps from NUM_MON-1 to 0.
//    - If such an i exists: cand<=i, cnt<=0, go to CONFIRM. If none, stay in SCAN.
//  - CONFIRM:
//    - If enable=0, go to IDLE.
//    - Else if qual[cand]=0: ptr<=(cand+1) mod NUM_MON, go to SCAN. The glitch is dropped.
//    - Else if cnt==CONFIRM_CYCLES-1: report_idx<=cand, report_stamp<=stamp, go to REPORT.
//    - Else cnt<=cnt+1.
//  - REPORT:
//    - report_valid=1. report_idx and report_stamp are held stable until report_ready=1.
//    - enable and clear are ignored here. report_valid never drops without a handshake.
//    - On handshake: report_valid<=0, deadlock<=1, ptr<=(cand+1) mod NUM_MON, go to HOLD.
//  - HOLD: deadlock stays 1 until clear=1. On clear: deadlock<=0, go to SCAN if
//    enable=1, otherwise to IDLE.
//  - clear in IDLE, SCAN or CONFIRM has no effect.
//  Latency: qual[i] rises in cycle t while in SCAN and stays high.
//   - CONFIRM runs in cycles t+1 .. t+CONFIRM_CYCLES.
//   - report_valid=1 from cycle t+CONFIRM_CYCLES+1.
//   - report_stamp = stamp at cycle t+CONFIRM_CYCLES.
//  Only one report is outstanding at a time. Other blocks are not tracked until HOLD exits.
// TESTING
//  1. Reset, enable=1, all mon_block=0 for 100 cycles -> report_valid=0, deadlock=0.
//  2. CONFIRM_CYCLES=16, enable from cycle 0, mon_block[5]=1 from cycle 10, ready=0
//     until cycle 32 -> report_valid=1 from cycle 27 with idx=5, stamp=26 held stable;
//     handshake at cycle 32 -> deadlock=1 from cycle 33.
//  3. mon_block[2]=1 for 8 cycles only -> no report; returns to SCAN with ptr=3.
//  4. mon_block[1] and mon_block[6] persistent, ptr=2 -> first report idx=6; after
//     handshake and clear, next report idx=1.
//  5. mon_block[4]=1 with mon_idle[4]=1 for 50 cycles -> no report.
//  6. Reset pulsed mid-CONFIRM, then mid-REPORT with ready=0 -> next cycle all outputs 0,
//     state IDLE, stamp=0.

Source files
------------

// File: rtl/deadlock_monitor_scheduler.sv
// Confirms persistent blocks from the per-instance AXIS deadlock monitors, picks one round-robin,
// and reports it with a cycle stamp over valid/ready; deadlock stays set until clear.
module deadlock_monitor_scheduler #(
    parameter int NUM_MON        = 8,
    parameter int IDX_W          = 3,
    parameter int CONFIRM_CYCLES = 16,
    parameter int CNT_W          = 5,
    parameter int STAMP_W        = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_MON-1:0] mon_block,
    input  logic [NUM_MON-1:0] mon_idle,
    output logic               report_valid,
    input  logic               report_ready,
    output logic [IDX_W-1:0]   report_idx,
    output logic [STAMP_W-1:0] report_stamp,
    output logic               deadlock,
    input  logic               clear
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_CONFIRM,
        S_REPORT,
        S_HOLD
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_cand;
    logic [CNT_W-1:0]   r_cnt;
    logic [STAMP_W-1:0] r_stamp;
    logic               r_valid;
    logic [IDX_W-1:0]   r_idx;
    logic [STAMP_W-1:0] r_rstamp;
    logic               r_deadlock;

    logic [NUM_MON-1:0] w_qual;
    logic               w_found;
    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W-1:0]   w_cand_next;

    assign w_qual      = mon_block & ~mon_idle;
    assign w_cand_next = (r_cand == IDX_W'(NUM_MON - 1)) ? '0 : r_cand + 1'b1;

    // Round-robin search starting at r_ptr; the sum is folded back below NUM_MON so
    // non-power-of-two instance counts wrap correctly.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < NUM_MON; k++) begin
            int v;
            v = int'(r_ptr) + k;
            if (v >= NUM_MON) v = v - NUM_MON;
            if (!w_found && w_qual[v[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = v[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_cand     <= '0;
            r_cnt      <= '0;
            r_stamp    <= '0;
            r_valid    <= 1'b0;
            r_idx      <= '0;
            r_rstamp   <= '0;
            r_deadlock <= 1'b0;
        end else begin
            r_stamp <= r_stamp + 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (enable) r_state <= S_SCAN;
                end
                S_SCAN: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end else if (w_found) begin
                        r_cand  <= w_pick;
                        r_cnt   <= '0;
                        r_state <= S_CONFIRM;
                    end
                end
                S_CONFIRM: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end else if (!w_qual[r_cand]) begin
                        r_ptr   <= w_cand_next;
                        r_state <= S_SCAN;
                    end else if (r_cnt == CNT_W'(CONFIRM_CYCLES - 1)) begin
                        r_idx    <= r_cand;
                        r_rstamp <= r_stamp;
                        r_valid  <= 1'b1;
                        r_state  <= S_REPORT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // Report is held until consumed; enable and clear cannot withdraw it.
                S_REPORT: begin
                    if (report_ready) begin
                        r_valid    <= 1'b0;
                        r_deadlock <= 1'b1;
                        r_ptr      <= w_cand_next;
                        r_state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (clear) begin
                        r_deadlock <= 1'b0;
                        r_state    <= enable ? S_SCAN : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign report_valid = r_valid;
    assign report_idx   = r_idx;
    assign report_stamp = r_rstamp;
    assign deadlock     = r_deadlock;

endmodule

// File: tb/tb_deadlock_monitor_scheduler.sv
// Scoreboard bench: a reference model queues expected reports, a negedge monitor checks them.
module tb_deadlock_monitor_scheduler;
    localparam int N  = 8;
    localparam int IW = 3;
    localparam int C  = 16;
    localparam int SW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [N-1:0]  mon_block = '0;
    logic [N-1:0]  mon_idle = '0;
    logic          report_valid;
    logic          report_ready = 1'b0;
    logic [IW-1:0] report_idx;
    logic [SW-1:0] report_stamp;
    logic          deadlock;
    logic          clear = 1'b0;

    deadlock_monitor_scheduler #(
        .NUM_MON(N), .IDX_W(IW), .CONFIRM_CYCLES(C), .CNT_W(5), .STAMP_W(SW)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .mon_block(mon_block), .mon_idle(mon_idle),
        .report_valid(report_valid), .report_ready(report_ready),
        .report_idx(report_idx), .report_stamp(report_stamp),
        .deadlock(deadlock), .clear(clear)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    // Reference model: phases named after the behaviour, not the RTL encoding.
    typedef struct {
        int     idx;
        longint stamp;
    } rep_t;
    rep_t exp_q[$];

    localparam int P_OFF = 0, P_LOOK = 1, P_WATCH = 2, P_OFFER = 3, P_LATCHED = 4;
    int          m_phase = P_OFF;
    int          m_next_from = 0;
    int          m_suspect = 0;
    int          m_seen = 0;
    logic [31:0] m_stamp = '0;
    bit          m_valid = 0;
    bit          m_dl = 0;

    task automatic model_step();
        logic [N-1:0] q;
        logic [31:0]  now;
        q = mon_block & ~mon_idle;
        if (reset) begin
            m_phase = P_OFF; m_next_from = 0; m_suspect = 0; m_seen = 0;
            m_stamp = '0; m_valid = 0; m_dl = 0;
            exp_q.delete();
            return;
        end
        now = m_stamp;
        m_stamp = m_stamp + 1;
        case (m_phase)
            P_OFF: if (enable) m_phase = P_LOOK;
            P_LOOK: begin
                if (!enable) m_phase = P_OFF;
                else begin
                    for (int k = 0; k < N; k++) begin
                        int j;
                        j = (m_next_from + k) % N;
                        if (q[j]) begin
                            m_suspect = j; m_seen = 0; m_phase = P_WATCH;
                            break;
                        end
                    end
                end
            end
            P_WATCH: begin
                if (!enable) m_phase = P_OFF;
                else if (!q[m_suspect]) begin
                    m_next_from = (m_suspect + 1) % N; m_phase = P_LOOK;
                end else if (m_seen + 1 == C) begin
                    rep_t r;
                    r.idx = m_suspect; r.stamp = longint'(now);
                    exp_q.push_back(r);
                    m_valid = 1; m_phase = P_OFFER;
                end else m_seen++;
            end
            P_OFFER: if (report_ready) begin
                m_valid = 0; m_dl = 1;
                m_next_from = (m_suspect + 1) % N; m_phase = P_LATCHED;
            end
            P_LATCHED: if (clear) begin
                m_dl = 0; m_phase = enable ? P_LOOK : P_OFF;
            end
            default: m_phase = P_OFF;
        endcase
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    // Monitor: compares outputs and pops the scoreboard on each handshake.
    bit     mon_on = 0;
    int     hs_count = 0;
    int     last_idx = -1;
    longint last_stamp = -1;

    always @(negedge clock) begin
        if (mon_on) begin
            check("report_valid", report_valid, m_valid);
            check("deadlock", deadlock, m_dl);
            if (report_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_report", exp_q.size(), 1);
                end else begin
                    check("report_idx", report_idx, exp_q[0].idx);
                    check("report_stamp", report_stamp, exp_q[0].stamp);
                    if (report_ready && !reset) begin
                        last_idx   = int'(report_idx);
                        last_stamp = longint'(report_stamp);
                        hs_count++;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, report_valid, 0);
        check({tag, "_deadlock"}, deadlock, 0);
        check({tag, "_idx"}, report_idx, 0);
        check({tag, "_stamp"}, report_stamp, 0);
    endtask

    initial begin
        int hs0;
        tick();
        tick();
        mon_on = 1;
        reset = 1'b0;

        // 1: idle system never reports
        enable = 1'b1;
        run(100);
        check("t1_valid", report_valid, 0);
        check("t1_deadlock", deadlock, 0);
        check("t1_hs", hs_count, 0);

        // 2: cycle-exact report timing from reset
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            mon_block    = (c >= 10) ? 8'h20 : 8'h00;
            report_ready = (c == 32);
            if (c == 26 || c == 27 || c == 32 || c == 33) begin
                check($sformatf("t2_valid_c%0d", c), report_valid, (c >= 27 && c <= 32));
                check($sformatf("t2_deadlock_c%0d", c), deadlock, (c >= 33));
            end
            if (c == 30) begin
                check("t2_idx", report_idx, 5);
                check("t2_stamp", report_stamp, 26);
            end
            tick();
        end
        check("t2_hs_idx", last_idx, 5);
        check("t2_hs_stamp", last_stamp, 26);
        mon_block = '0; report_ready = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;

        // 3: short glitch is dropped
        hs0 = hs_count;
        mon_block = 8'h04; run(8);
        mon_block = 8'h00; run(30);
        check("t3_no_report", hs_count, hs0);

        // 4: round-robin order 1, then 6 (from ptr 2), then 1
        report_ready = 1'b1;
        mon_block = 8'h02; run(25);
        check("t4_first", last_idx, 1);
        clear = 1'b1; tick(); clear = 1'b0;
        mon_block = 8'h42; run(25);
        check("t4_second", last_idx, 6);
        clear = 1'b1; tick(); clear = 1'b0;
        run(25);
        check("t4_third", last_idx, 1);
        mon_block = 8'h00;
        clear = 1'b1; tick(); clear = 1'b0;
        run(5);

        // 5: idle disqualifies a block
        hs0 = hs_count;
        mon_block = 8'h10; mon_idle = 8'h10; run(50);
        check("t5_no_report", hs_count, hs0);
        check("t5_valid", report_valid, 0);
        mon_block = '0; mon_idle = '0;

        // 6: reset mid-CONFIRM, then mid-REPORT
        mon_block = 8'h01; run(5);
        do_reset();
        check_zero("t6a");
        report_ready = 1'b0;
        mon_block = 8'h08; run(25);
        check("t6_pre_valid", report_valid, 1);
        check("t6_pre_idx", report_idx, 3);
        check("t6_pre_stamp", report_stamp, 17);
        do_reset();
        check_zero("t6b");
        mon_block = '0;

        // Random phase
        for (int i = 0; i < 4000; i++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 39) == 0) mon_block[b] = ~mon_block[b];
            for (int b = 0; b < N; b++)
                mon_idle[b] = ($urandom_range(0, 15) == 0);
            enable       = ($urandom_range(0, 49) != 0);
            report_ready = $urandom_range(0, 1) == 1;
            clear        = ($urandom_range(0, 9) == 0);
            reset        = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0;
        run(2);
        mon_on = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
